alu_req_arbiter: RTL and testbench

Sequencer and two-port arbiter for the shared N-bit ALU. It accepts operation requests from two independent requesters and grants one at a time, round-robin or fixed priority. It drives the granted operands into the ALU, captures the result and NZCV flags, and returns them over a per-requester valid/ack response handshake. It sits between the instruction-issue logic and the single ALU instance, which stays purely combinational.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/arb_pick2.sv | 37 +++
 rtl/alu_req_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the ALU request arbiter. It holds the ALU
//                control codes, the arbiter FSM states and the NZCV flags
//                struct.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_OP_ADD  = 3'b000,
        ALU_OP_SLL  = 3'b001,
        ALU_OP_SRL  = 3'b010,
        ALU_OP_XOR  = 3'b011,
        ALU_OP_OR   = 3'b100,
        ALU_OP_NOT  = 3'b101,
        ALU_OP_AND  = 3'b110,
        ALU_OP_RSVD = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    localparam alu_flags_t C_FLAGS_CLEAR = '0;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/arb_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pick2
//  Description : Combinational two-way grant picker.
//                Macro ALU_ARB_RR_EN defined   -> round-robin: when both are
//                                                 valid, pick the requester
//                                                 not granted last.
//                Macro ALU_ARB_RR_EN undefined -> fixed priority: requester 0
//                                                 always wins.
//  Ports       : i_valid0/i_valid1 request valids, i_last last-granted index,
//                o_gnt_vld some request is pending, o_gnt_idx winner index.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_pick2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last,
    output logic o_gnt_vld,
    output logic o_gnt_idx
);

    assign o_gnt_vld = i_valid0 | i_valid1;

`ifdef ALU_ARB_RR_EN
    // Contention goes to the side that did not win last time; otherwise
    // the only valid side wins.
    assign o_gnt_idx = (i_valid0 & i_valid1) ? ~i_last : ~i_valid0;
`else
    assign o_gnt_idx = ~i_valid0;

    // The pointer input has no role under fixed priority.
    logic w_unused_last;
    assign w_unused_last = i_last;
`endif

endmodule : arb_pick2
`default_nettype wire

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_req_arbiter
//  Description : Two-port request arbiter and sequencer for a shared,
//                purely combinational ALU. It runs IDLE -> EXEC -> RESP per
//                operation. A grant latches the operands. EXEC drives them to
//                the ALU and captures the result and flags. RESP holds the
//                response until the granted requester acks.
//  Config      : ALU_ARB_RR_EN defined   -> round-robin arbitration
//                                           (last-grant pointer resets to 1).
//                ALU_ARB_RR_EN undefined -> fixed priority, req0 wins.
//  Ports       : clk/rst            clock, synchronous active-high reset
//                reqX_*             request handshake and operands
//                rspX_valid/ack     per-requester response handshake
//                rsp_result/flags/err shared response payload
//                alu_*              connection to the external ALU
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [width-1:0] req0_a,
    input  logic [width-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req0_cin,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [width-1:0] req1_a,
    input  logic [width-1:0] req1_b,
    input  logic [2:0]       req1_op,
    input  logic             req1_cin,

    output logic             rsp0_valid,
    input  logic             rsp0_ack,
    output logic             rsp1_valid,
    input  logic             rsp1_ack,
    output logic [width-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,

    output logic [width-1:0] alu_a,
    output logic [width-1:0] alu_b,
    output logic [2:0]       alu_control,
    output logic             alu_carryin,
    input  logic [width-1:0] alu_result,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;

    logic [width-1:0] r_a;
    logic [width-1:0] r_b;
    alu_op_t          r_op;
    logic             r_cin;
    logic             r_gnt;

    logic [width-1:0] r_result;
    alu_flags_t       r_flags;
    logic             r_err;

    logic             w_gnt_vld;
    logic             w_gnt_idx;
    logic             w_last;
    logic             w_accept;

    // ------------------------------------------------------------------
    // Last-grant pointer
    // ------------------------------------------------------------------
`ifdef ALU_ARB_RR_EN
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_gnt_idx;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = 1'b1;
`endif

    arb_pick2 u_pick (
        .i_valid0  (req0_valid),
        .i_valid1  (req1_valid),
        .i_last    (w_last),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_idx (w_gnt_idx)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                // Ready depends only on state and the valids. It is held
                // low while reset is asserted.
                if (!rst && w_gnt_vld) begin
                    w_accept    = 1'b1;
                    req0_ready  = ~w_gnt_idx;
                    req1_ready  = w_gnt_idx;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = ~r_gnt;
                rsp1_valid = r_gnt;
                // The ack on the non-granted port is ignored.
                if (r_gnt ? rsp1_ack : rsp0_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= ALU_OP_ADD;
            r_cin    <= 1'b0;
            r_gnt    <= 1'b0;
            r_result <= '0;
            r_flags  <= C_FLAGS_CLEAR;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gnt <= w_gnt_idx;
                if (w_gnt_idx) begin
                    r_a   <= req1_a;
                    r_b   <= req1_b;
                    r_op  <= alu_op_t'(req1_op);
                    r_cin <= req1_cin;
                end else begin
                    r_a   <= req0_a;
                    r_b   <= req0_b;
                    r_op  <= alu_op_t'(req0_op);
                    r_cin <= req0_cin;
                end
            end
            if (r_state == EXEC) begin
                if (r_op == ALU_OP_RSVD) begin
                    // The ALU output for the reserved code is meaningless,
                    // so the response is reported as an error.
                    r_result <= '0;
                    r_flags  <= C_FLAGS_CLEAR;
                    r_err    <= 1'b1;
                end else begin
                    r_result <= alu_result;
                    r_flags  <= alu_flags_t'({alu_n, alu_z, alu_c, alu_v});
                    r_err    <= 1'b0;
                end
            end
        end
    end

    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_control = r_op;
    assign alu_carryin = r_cin;

    assign rsp_result  = r_result;
    assign rsp_flags   = r_flags;
    assign rsp_err     = r_err;

endmodule : alu_req_arbiter
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_req_arbiter
//  Description : Self-checking bench for alu_req_arbiter. It includes a
//                behavioural ALU, a reference grant policy and a
//                transaction-level timing model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_req_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_cin;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         rsp0_valid, rsp0_ack, rsp1_valid, rsp1_ack;
    logic [W-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         rsp_err;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_control;
    logic         alu_carryin, alu_n, alu_z, alu_c, alu_v;

    int checks = 0;
    int errors = 0;
    bit last_model;
    logic [W-1:0] obs_res;
    logic [3:0]   obs_flags;
    logic         obs_err;

    always #5 clk = ~clk;

    alu_req_arbiter #(.width(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op), .req1_cin(req1_cin),
        .rsp0_valid(rsp0_valid), .rsp0_ack(rsp0_ack),
        .rsp1_valid(rsp1_valid), .rsp1_ack(rsp1_ack),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_carryin(alu_carryin), .alu_result(alu_result),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v)
    );

    // Behavioural ALU: {result, n, z, c, v}. The reserved code yields junk
    // so that the arbiter must be seen to ignore it.
    function automatic logic [11:0] tb_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op, input logic cin);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v;
        s = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd1: r = a << b[2:0];
            3'd2: r = a >> b[2:0];
            3'd3: r = a ^ b;
            3'd4: r = a | b;
            3'd5: r = ~a;
            3'd6: r = a & b;
            default: return {8'hA5, 4'hF};
        endcase
        return {r, r[7], (r == 8'd0), c, v};
    endfunction

    always_comb {alu_result, alu_n, alu_z, alu_c, alu_v} =
        tb_alu(alu_a, alu_b, alu_control, alu_carryin);

    // Reference grant policy.
    function automatic int pick(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
            return last_model ? 0 : 1;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input bit allow_rsvd);
        logic [2:0] op;
        op = 3'($urandom_range(0, 6));
        if (allow_rsvd && ($urandom_range(0, 7) == 0)) op = 3'd7;
        if (p == 0) begin
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            req0_op = op; req0_cin = 1'($urandom);
        end else begin
            req1_a = 8'($urandom); req1_b = 8'($urandom);
            req1_op = op; req1_cin = 1'($urandom);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready0"}, req0_ready, 0);
        check({tag, "_ready1"}, req1_ready, 0);
        check({tag, "_rsp0v"}, rsp0_valid, 0);
        check({tag, "_rsp1v"}, rsp1_valid, 0);
        check({tag, "_result"}, rsp_result, 0);
        check({tag, "_flags"}, rsp_flags, 0);
        check({tag, "_err"}, rsp_err, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_ctl"}, alu_control, 0);
        check({tag, "_alu_cin"}, alu_carryin, 0);
    endtask

    // One transaction. It is entered and left just after a rising edge.
    // Expected timing: ready in the accept cycle, EXEC one cycle later, and
    // the response from the following cycle until the ack edge.
    task automatic run_one(input int ack_delay, input bit mid_rst,
                           input bit keep_valid, input bit raise0);
        int         w;
        logic [7:0] ea, eb;
        logic [2:0] eop;
        logic       ecin, eerr;
        logic [11:0] e;
        @(negedge clk);
        w = pick(req0_valid, req1_valid);
        checks++;
        if (w < 0) begin
            errors++;
            $error("FAIL no_request observed=none expected=pending");
            return;
        end
        check("idle_rsp0v", rsp0_valid, 0);
        check("idle_rsp1v", rsp1_valid, 0);
        check("ready0", req0_ready, (w == 0));
        check("ready1", req1_ready, (w == 1));
        ea   = (w == 0) ? req0_a   : req1_a;
        eb   = (w == 0) ? req0_b   : req1_b;
        eop  = (w == 0) ? req0_op  : req1_op;
        ecin = (w == 0) ? req0_cin : req1_cin;
        if (eop == 3'd7) begin
            e = 12'd0; eerr = 1'b1;
        end else begin
            e = tb_alu(ea, eb, eop, ecin); eerr = 1'b0;
        end
        @(posedge clk); #1;
        last_model = w[0];
        if (w == 0) begin
            req0_valid = keep_valid; set_req(0, 1'b1);
        end else begin
            req1_valid = keep_valid; set_req(1, 1'b1);
        end
        if (raise0) begin
            req0_valid = 1'b1; set_req(0, 1'b0);
        end
        @(negedge clk);
        check("exec_ready0", req0_ready, 0);
        check("exec_ready1", req1_ready, 0);
        check("exec_rsp0v", rsp0_valid, 0);
        check("exec_rsp1v", rsp1_valid, 0);
        check("exec_alu_a", alu_a, ea);
        check("exec_alu_b", alu_b, eb);
        check("exec_alu_ctl", alu_control, eop);
        check("exec_alu_cin", alu_carryin, ecin);
        if (mid_rst) begin
            rst = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            check_reset_vals("midrst");
            last_model = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        @(posedge clk); #1;
        for (int k = 0; k <= ack_delay; k++) begin
            @(negedge clk);
            check("rsp0v", rsp0_valid, (w == 0));
            check("rsp1v", rsp1_valid, (w == 1));
            check("rsp_result", rsp_result, e[11:4]);
            check("rsp_flags", rsp_flags, e[3:0]);
            check("rsp_err", rsp_err, eerr);
            check("resp_ready0", req0_ready, 0);
            check("resp_ready1", req1_ready, 0);
            if (k == 0) begin
                obs_res = rsp_result; obs_flags = rsp_flags; obs_err = rsp_err;
            end
            if (w == 0) begin
                rsp0_ack = (k == ack_delay); rsp1_ack = 1'($urandom);
            end else begin
                rsp1_ack = (k == ack_delay); rsp0_ack = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        rsp0_ack = 1'b0;
        rsp1_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        last_model = 1'b1;
        rsp0_ack = 1'b0; rsp1_ack = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        set_req(0, 1'b0); set_req(1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Simultaneous requests from reset, three rounds, immediate ack.
        for (int i = 0; i < 3; i++) run_one(0, 1'b0, 1'b1, 1'b0);

        // Single add.
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_a = 8'h0F; req0_b = 8'h01; req0_op = 3'b000; req0_cin = 1'b0;
        run_one(0, 1'b0, 1'b0, 1'b0);
        check("add_result", obs_res, 8'h10);
        check("add_flags", obs_flags, 4'h0);
        check("add_err", obs_err, 1'b0);

        // Held response on req1 with req0 waiting.
        req1_valid = 1'b1; set_req(1, 1'b0);
        run_one(5, 1'b0, 1'b0, 1'b1);
        run_one(0, 1'b0, 1'b0, 1'b0);

        // Reserved opcode.
        req0_valid = 1'b1;
        req0_a = 8'hFF; req0_b = 8'h3C; req0_op = 3'b111; req0_cin = 1'b1;
        run_one(0, 1'b0, 1'b0, 1'b0);
        check("rsvd_result", obs_res, 8'h00);
        check("rsvd_flags", obs_flags, 4'h0);
        check("rsvd_err", obs_err, 1'b1);

        // Reset during EXEC, then a normal request.
        req0_valid = 1'b1; set_req(0, 1'b0);
        run_one(0, 1'b1, 1'b1, 1'b0);
        run_one(0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_valid = 1'b1; set_req(0, 1'b1);
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_valid = 1'b1; set_req(1, 1'b1);
            end
            if (!req0_valid && !req1_valid) begin
                req0_valid = 1'b1; set_req(0, 1'b1);
            end
            run_one($urandom_range(0, 3), 1'b0, 1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_req_arbiter
`default_nettype wire
